icap_reboot_master: RTL and testbench

ICAP_REBOOT_MASTER -- requirements
Module: icap_reboot_master

---
 rtl/icap_pkg.sv | 46 ++++
 rtl/icap_seq_rom.sv | 34 +++
 rtl/icap_reboot_master.sv | 162 ++++++++++++++++
 tb/tb_icap_reboot_master.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icap_pkg.sv
// icap_pkg -- shared definitions for the ICAP reboot master.
//   state_e       : controller state encoding (S_RD_REQ exists only when
//                   ICAP_READBACK_EN is defined)
//   W_*           : the 8 constant 16-bit words of the IPROG command sequence
//   SEQ_LEN       : number of byte writes in one reboot sequence (20)
//   IDX_W/IDX_END : byte index width and the "sequence finished" index value
// Optional feature macro: ICAP_READBACK_EN.
package icap_pkg;

`ifdef ICAP_READBACK_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_GAP    = 3'd2,
      S_DONE   = 3'd3,
      S_ERR    = 3'd4,
      S_RD_REQ = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_GAP  = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_e;
`endif

   localparam int SEQ_LEN = 20;
   localparam int IDX_W   = 5;
   // Index value reached after the last byte has been acknowledged.
   localparam logic [IDX_W-1:0] IDX_END = IDX_W'(SEQ_LEN);

   // Constant words of the sequence (dummy, sync, WBSTAR, CMD, IPROG, NOPs).
   localparam logic [15:0] W_DUMMY  = 16'hFFFF;
   localparam logic [15:0] W_SYNC   = 16'hAA99;
   localparam logic [15:0] W_WBST_L = 16'h3261;
   localparam logic [15:0] W_WBST_H = 16'h3281;
   localparam logic [15:0] W_CMD    = 16'h30A1;
   localparam logic [15:0] W_IPROG  = 16'h000E;
   localparam logic [15:0] W_NOP0   = 16'h2000;
   localparam logic [15:0] W_NOP1   = 16'h2000;
   // Upper byte of the word that carries boot_addr[23:16].
   localparam logic [7:0]  B_ADDR_HI_OP = 8'h0B;

endpackage

// File: rtl/icap_seq_rom.sv
// icap_seq_rom -- combinational lookup of one byte of the reboot sequence.
//   idx       : byte index 0..19 (even = high byte of a word, odd = low byte)
//   boot_addr : latched flash address inserted into words 3 and 5
//   byte_o    : byte to transmit
module icap_seq_rom
   import icap_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic [23:0]      boot_addr,
   output logic [7:0]       byte_o
);

   logic [15:0] word;

   always_comb begin
      word = 16'h0000;
      case (idx[4:1])
         4'd0:    word = W_DUMMY;
         4'd1:    word = W_SYNC;
         4'd2:    word = W_WBST_L;
         4'd3:    word = boot_addr[15:0];
         4'd4:    word = W_WBST_H;
         4'd5:    word = {B_ADDR_HI_OP, boot_addr[23:16]};
         4'd6:    word = W_CMD;
         4'd7:    word = W_IPROG;
         4'd8:    word = W_NOP0;
         4'd9:    word = W_NOP1;
         default: word = 16'h0000;
      endcase
      // High byte goes out first.
      byte_o = idx[0] ? word[7:0] : word[15:8];
   end

endmodule

// File: rtl/icap_reboot_master.sv
// icap_reboot_master -- Wishbone master that streams the ICAP IPROG reboot
// sequence (20 byte writes) for a target bitstream address.
//   clk, reset_n        : clock, asynchronous active-low reset
//   go, boot_addr       : start request and 24-bit flash byte address
//   busy, done, err     : busy level, completion pulse, timeout pulse
//   cyc_o, stb_o, we_o,
//   dat_o, dat_i, ack_i : Wishbone master bus (bytes on dat_o[7:0])
//   rd_req, rd_data     : single-byte readback (only with ICAP_READBACK_EN)
// TIMEOUT is the number of REQ cycles allowed without ack_i (2..255).
// Optional feature macro: ICAP_READBACK_EN.
module icap_reboot_master
   import icap_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        go,
   input  logic [23:0] boot_addr,
`ifdef ICAP_READBACK_EN
   input  logic        rd_req,
   output logic [7:0]  rd_data,
`endif
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i
);

   // Last value of the REQ cycle counter before the transaction is abandoned.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [23:0]      addr_q, addr_d;
   logic [7:0]       tmo_q, tmo_d;
   logic [7:0]       rom_byte;
`ifdef ICAP_READBACK_EN
   logic [7:0]       rd_data_q, rd_data_d;
`endif

   // Only dat_i[7:0] is consumed, and only by readback.
   logic unused_dat_i;
   assign unused_dat_i = ^dat_i;

   icap_seq_rom u_rom (
      .idx       (idx_q),
      .boot_addr (addr_q),
      .byte_o    (rom_byte)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         addr_q    <= '0;
         tmo_q     <= '0;
`ifdef ICAP_READBACK_EN
         rd_data_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         tmo_q     <= tmo_d;
`ifdef ICAP_READBACK_EN
         rd_data_q <= rd_data_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      tmo_d     = tmo_q;
`ifdef ICAP_READBACK_EN
      rd_data_d = rd_data_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d = S_REQ;
               idx_d   = '0;
               addr_d  = boot_addr;
               tmo_d   = '0;
            end
`ifdef ICAP_READBACK_EN
            else if (rd_req) begin
               state_d = S_RD_REQ;
               tmo_d   = '0;
            end
`endif
         end
         S_REQ: begin
            if (ack_i) begin
               state_d = S_GAP;
               idx_d   = idx_q + 5'd1;
               tmo_d   = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_ERR;
               tmo_d   = '0;
            end else begin
               tmo_d   = tmo_q + 8'd1;
            end
         end
`ifdef ICAP_READBACK_EN
         S_RD_REQ: begin
            if (ack_i) begin
               state_d   = S_GAP;
               rd_data_d = dat_i[7:0];
               // Reuse the end-of-sequence index so GAP routes to DONE.
               idx_d     = IDX_END;
               tmo_d     = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_ERR;
               tmo_d   = '0;
            end else begin
               tmo_d   = tmo_q + 8'd1;
            end
         end
`endif
         S_GAP:   state_d = (idx_q == IDX_END) ? S_DONE : S_REQ;
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode straight from the state register, so the async reset
   // clears them immediately and stb_o drops the cycle after an ack.
   always_comb begin
      busy  = (state_q != S_IDLE);
      done  = (state_q == S_DONE);
      err   = (state_q == S_ERR);
      cyc_o = 1'b0;
      we_o  = 1'b0;
      dat_o = '0;
      case (state_q)
         S_REQ: begin
            cyc_o = 1'b1;
            we_o  = 1'b1;
            dat_o = {24'h0, rom_byte};
         end
`ifdef ICAP_READBACK_EN
         S_RD_REQ: cyc_o = 1'b1;
`endif
         default: ;
      endcase
      stb_o = cyc_o;
   end

`ifdef ICAP_READBACK_EN
   assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_icap_reboot_master.sv
// tb_icap_reboot_master -- directed and randomized checks of the ICAP reboot
// master against a sequence/latency model. Optional macro: ICAP_READBACK_EN.
module tb_icap_reboot_master;

   localparam int TIMEOUT = 16;
   localparam int NB      = 20;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        go;
   logic [23:0] boot_addr;
   logic        busy, done, err, cyc_o, stb_o, we_o;
   logic [31:0] dat_o, dat_i;
   logic        ack_i;
`ifdef ICAP_READBACK_EN
   logic        rd_req;
   logic [7:0]  rd_data;
`endif

   icap_reboot_master #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .go        (go),
      .boot_addr (boot_addr),
`ifdef ICAP_READBACK_EN
      .rd_req    (rd_req),
      .rd_data   (rd_data),
`endif
      .busy      (busy),
      .done      (done),
      .err       (err),
      .cyc_o     (cyc_o),
      .stb_o     (stb_o),
      .we_o      (we_o),
      .dat_o     (dat_o),
      .dat_i     (dat_i),
      .ack_i     (ack_i)
   );

   always #5 clk = ~clk;

   int ntests = 0;
   int nfail  = 0;

   // Responder / monitor state.
   int         lat_tab [NB];   // stb cycle (1-based) in which byte i is acked
   int         stall_byte;     // byte that is never acked (-1 none)
   bit         spurious;       // random ack_i pulses while stb_o is low
   int         stb_run, low_run, cyc_n;
   int         done_cnt, err_cnt, done_at, err_at, busy_low;
   int         stb_after_ack, gap_bad;
   logic [7:0] wr_bytes [$];
   logic       we_log   [$];
   int         hi_bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected byte i of the sequence for address a, from the word list.
   function automatic logic [7:0] model_byte(int i, logic [23:0] a);
      logic [15:0] w [10];
      w = '{16'hFFFF, 16'hAA99, 16'h3261, a[15:0], 16'h3281,
            {8'h0B, a[23:16]}, 16'h30A1, 16'h000E, 16'h2000, 16'h2000};
      return (i % 2 == 0) ? w[i/2][15:8] : w[i/2][7:0];
   endfunction

   // Advance one clock: log a transfer completing at this edge, then sample
   // outputs 1ns after the edge and drive the responder for the new cycle.
   task automatic tick();
      bit xfer;
      int idx;
      xfer = stb_o && ack_i;
      if (xfer) begin
         wr_bytes.push_back(dat_o[7:0]);
         we_log.push_back(we_o);
         if (dat_o[31:8] != 24'h0) hi_bad++;
      end
      @(posedge clk);
      #1;
      cyc_n++;
      if (!busy) busy_low++;
      if (done) begin done_cnt++; if (done_at < 0) done_at = cyc_n; end
      if (err)  begin err_cnt++;  if (err_at < 0)  err_at  = cyc_n; end
      if (xfer && stb_o) stb_after_ack++;
      if (!cyc_o) low_run++;
      else begin
         if (low_run > 0 && wr_bytes.size() > 0 && low_run != 1) gap_bad++;
         low_run = 0;
      end
      if (stb_o) stb_run++; else stb_run = 0;
      idx = wr_bytes.size();
      if (stb_o)
         ack_i = (idx < NB) && (idx != stall_byte) && (stb_run == lat_tab[idx]);
      else
         ack_i = spurious ? ($urandom_range(0, 3) == 0) : 1'b0;
   endtask

   task automatic clear_mon(input int stall, input bit spur);
      wr_bytes.delete();
      we_log.delete();
      done_cnt = 0; err_cnt = 0; done_at = -1; err_at = -1;
      busy_low = 0; stb_after_ack = 0; gap_bad = 0; hi_bad = 0; low_run = 0;
      stall_byte = stall; spurious = spur;
   endtask

   // One reboot transaction; checks bytes, timing, pulses and bus rules.
   task automatic run_txn(input string name, input logic [23:0] a, input int stall,
                          input int repulse_at, input bit spur);
      int  k, exp_cyc;
      bit  rep_done;
      clear_mon(stall, spur);
      rep_done  = 0;
      boot_addr = a;
      go        = 1'b1;
      cyc_n     = 0;
      tick();
      go        = 1'b0;
      boot_addr = 24'($urandom);
      for (int c = 0; c < 2000 && done_at < 0 && err_at < 0; c++) begin
         if (repulse_at >= 0 && !rep_done && wr_bytes.size() == repulse_at && stb_o) begin
            go = 1'b1; boot_addr = ~a; rep_done = 1;
         end
         tick();
         go = 1'b0;
      end
      chk({name, " complete"}, 32'(done_at >= 0 || err_at >= 0), 32'd1);
      k = (stall >= 0) ? stall : NB;
      exp_cyc = 0;
      for (int i = 0; i < k; i++) exp_cyc += lat_tab[i] + 1;
      chk({name, " nbytes"}, 32'(wr_bytes.size()), 32'(k));
      for (int i = 0; i < k && i < wr_bytes.size(); i++)
         if (wr_bytes[i] !== model_byte(i, a))
            chk($sformatf("%s byte%0d", name, i), {24'h0, wr_bytes[i]}, {24'h0, model_byte(i, a)});
      ntests++;
      foreach (we_log[i]) if (we_log[i] !== 1'b1) hi_bad++;
      if (hi_bad != 0) begin
         nfail++;
         $error("FAIL %s we/dat_hi: observed %0d bad writes expected 0", name, hi_bad);
      end
      if (stall >= 0) begin
         chk({name, " err_at"}, 32'(err_at), 32'(exp_cyc + TIMEOUT + 1));
         chk({name, " no_done"}, 32'(done_at), 32'hFFFF_FFFF);
      end else begin
         chk({name, " done_at"}, 32'(done_at), 32'(exp_cyc + 1));
         chk({name, " no_err"}, 32'(err_at), 32'hFFFF_FFFF);
      end
      chk({name, " busy_held"}, 32'(busy_low), 32'd0);
      chk({name, " stb_after_ack"}, 32'(stb_after_ack), 32'd0);
      chk({name, " one_gap"}, 32'(gap_bad), 32'd0);
      tick();
      chk({name, " idle_after"}, {31'h0, busy}, 32'd0);
      repeat (3) tick();
      chk({name, " pulses"}, 32'(done_cnt + err_cnt), 32'd1);
   endtask

   initial begin
      logic [7:0] exp27 [NB];
      exp27 = '{8'hFF, 8'hFF, 8'hAA, 8'h99, 8'h32, 8'h61, 8'h34, 8'h56, 8'h32, 8'h81,
                8'h0B, 8'h12, 8'h30, 8'hA1, 8'h00, 8'h0E, 8'h20, 8'h00, 8'h20, 8'h00};
      reset_n = 1'b0; go = 1'b0; boot_addr = '0; ack_i = 1'b0; dat_i = '0;
`ifdef ICAP_READBACK_EN
      rd_req = 1'b0;
`endif
      stb_run = 0; cyc_n = 0;
      clear_mon(-1, 0);
      foreach (lat_tab[i]) lat_tab[i] = 3;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst outputs", {26'h0, busy, done, err, cyc_o, stb_o, we_o}, 32'd0);
      chk("rst dat_o", dat_o, 32'd0);
      reset_n = 1'b1;
      tick();

      // Nominal sequence at 0x123456 with the 3-stb-cycle responder.
      run_txn("nominal", 24'h123456, -1, -1, 0);
      for (int i = 0; i < NB && i < wr_bytes.size(); i++)
         if (wr_bytes[i] !== exp27[i])
            chk($sformatf("nominal lit byte%0d", i), {24'h0, wr_bytes[i]}, {24'h0, exp27[i]});
      chk("nominal 80 cycles", 32'(done_at), 32'd81);

      // Byte 5 never acknowledged.
      run_txn("stall5", 24'hABCDEF, 5, -1, 0);
      // Timeout boundaries: first and last byte.
      run_txn("stall0", 24'h000001, 0, -1, 0);
      run_txn("stall19", 24'hFEDCBA, 19, -1, 0);
      // Ack in the very last allowed cycle is accepted.
      foreach (lat_tab[i]) lat_tab[i] = TIMEOUT;
      run_txn("lat_max", 24'h5A5A5A, -1, -1, 0);
      // go re-pulsed mid-sequence is ignored.
      foreach (lat_tab[i]) lat_tab[i] = 3;
      run_txn("repulse", 24'h0F0F0F, -1, 7, 1);

      // Reset during byte 10 REQ: bus drops before the next edge.
      clear_mon(-1, 0);
      boot_addr = 24'h777777; go = 1'b1; tick(); go = 1'b0;
      for (int c = 0; c < 200 && !(wr_bytes.size() == 10 && stb_o); c++) tick();
      chk("rst reached byte10", 32'(wr_bytes.size() == 10 && stb_o), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst async bus", {29'h0, cyc_o, stb_o, busy}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      done_cnt = 0; err_cnt = 0;
      repeat (30) tick();
      chk("rst no pulses", 32'(done_cnt + err_cnt), 32'd0);
      chk("rst idle", {30'h0, busy, cyc_o}, 32'd0);

      // Randomized transactions: latency, address, stalls and stray acks.
      for (int t = 0; t < 6; t++) begin
         int st;
         foreach (lat_tab[i]) lat_tab[i] = $urandom_range(1, 6);
         st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
         run_txn($sformatf("rand%0d", t), 24'($urandom), st, -1, 1);
      end

`ifdef ICAP_READBACK_EN
      // Single readback.
      clear_mon(-1, 0);
      lat_tab[0] = 3;
      dat_i = 32'h0000_00A5;
      rd_req = 1'b1; cyc_n = 0; tick(); rd_req = 1'b0;
      for (int c = 0; c < 200 && done_at < 0 && err_at < 0; c++) tick();
      chk("rd nreads", 32'(wr_bytes.size()), 32'd1);
      if (we_log.size() > 0) chk("rd we", {31'h0, we_log[0]}, 32'd0);
      if (wr_bytes.size() > 0) chk("rd dat_o", {24'h0, wr_bytes[0]}, 32'd0);
      chk("rd done_at", 32'(done_at), 32'd5);
      chk("rd data", {24'h0, rd_data}, 32'h0000_00A5);
      tick();
      dat_i = '0;
      // go and rd_req together: go wins.
      foreach (lat_tab[i]) lat_tab[i] = 2;
      rd_req = 1'b1;
      run_txn("go_wins", 24'h246801, -1, -1, 0);
      rd_req = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
